// File: rtl/privtrap_pkg.sv
// privtrap_pkg: privilege modes, cause codes, trap priority orders and config type
package privtrap_pkg;
  typedef struct packed {
    logic S_SUPPORTED;
    logic U_SUPPORTED;
  } cvw_t;
  localparam cvw_t CVW_DEFAULT = '{S_SUPPORTED: 1'b1, U_SUPPORTED: 1'b1};
  localparam logic [1:0] M_MODE = 2'b11;
  localparam logic [1:0] S_MODE = 2'b01;
  localparam logic [1:0] U_MODE = 2'b00;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR = 4'd2;
  localparam int N_INT = 6;
  localparam int N_EXC = 14;
  localparam logic [3:0] INT_PRIO [N_INT] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};
  localparam logic [3:0] EXC_PRIO [N_EXC] = '{4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9,
                                               4'd11, 4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5};
  localparam logic [11:0] INT_MASK = 12'hAAA;
  localparam logic [15:0] EXC_MASK = 16'hBBFF;
  typedef enum logic {RUN, WFI} wfi_state_t;
endpackage

// File: rtl/privtrap_trapcause.sv
// trapcause: priority encoder over enabled interrupts then exceptions
module trapcause
  import privtrap_pkg::*;
(
  input  logic [11:0] int_en,
  input  logic [15:0] exc,
  output logic [4:0]  cause,
  output logic        taken
);
  always_comb begin
    cause = '0;
    for (int i = N_EXC - 1; i >= 0; i--)
      if (exc[EXC_PRIO[i]]) cause = {1'b0, EXC_PRIO[i]};
    for (int i = N_INT - 1; i >= 0; i--)
      if (int_en[INT_PRIO[i]]) cause = {1'b1, INT_PRIO[i]};
    taken = |(int_en & INT_MASK) | |(exc & EXC_MASK);
  end
endmodule

// File: rtl/privtrap.sv
// privtrap: privilege mode, trap/return validation and WFI wait control
// PRIVTRAP_WFI_TIMEOUT_EN enables the TW timeout counter; otherwise TW wfi traps at once
module privtrap
  import privtrap_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT
`ifdef PRIVTRAP_WFI_TIMEOUT_EN
  , parameter int WFI_TIMEOUT_BITS = 8
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallW,
  input  logic        InstrValidM,
  input  logic        mretM,
  input  logic        sretM,
  input  logic        wfiM,
  input  logic [15:0] ExcM,
  input  logic [11:0] MIP_REGW,
  input  logic [11:0] MIE_REGW,
  input  logic [11:0] MIDELEG_REGW,
  input  logic [15:0] MEDELEG_REGW,
  input  logic        STATUS_MIE,
  input  logic        STATUS_SIE,
  input  logic        STATUS_TSR,
  input  logic        STATUS_TW,
  input  logic        STATUS_SPP,
  input  logic [1:0]  STATUS_MPP,
  output logic        TrapM,
  output logic        mretValidM,
  output logic        sretValidM,
  output logic [1:0]  NextPrivilegeModeM,
  output logic [1:0]  PrivilegeModeW,
  output logic [4:0]  CauseM,
  output logic        WFIStallM
);
  wfi_state_t state;
  logic        in_m, in_s, in_u, wfi_wait, wake, m_ie, s_ie;
  logic        timeout, tw_illegal, sret_bad, illegal, trap_deleg, legal_wfi;
  logic [11:0] pend, int_en;
  logic [15:0] exc, mideleg16;
  logic [1:0]  target;
  assign in_m = PrivilegeModeW == M_MODE;
  assign in_s = PrivilegeModeW == S_MODE;
  assign in_u = PrivilegeModeW == U_MODE;
  assign wfi_wait = state == WFI;
  assign WFIStallM = wfi_wait;
  assign pend = MIP_REGW & MIE_REGW;
  assign wake = |pend;
  assign m_ie = !in_m | STATUS_MIE;
  assign s_ie = in_u | (in_s & STATUS_SIE);
  // interrupts may also wake and trap from the WFI wait, with no valid instruction
  assign int_en = (InstrValidM | wfi_wait)
                ? pend & ((~MIDELEG_REGW & {12{m_ie}}) | (MIDELEG_REGW & {12{s_ie}}))
                : '0;
`ifdef PRIVTRAP_WFI_TIMEOUT_EN
  logic [WFI_TIMEOUT_BITS-1:0] wfi_cnt;
  assign timeout = wfi_wait & STATUS_TW & !in_m & (&wfi_cnt) & !wake;
  assign tw_illegal = 1'b0;
  always_ff @(posedge clk)
    if (reset) wfi_cnt <= '0;
    else if (!StallW) wfi_cnt <= !wfi_wait ? '0 : (&wfi_cnt) ? wfi_cnt : wfi_cnt + WFI_TIMEOUT_BITS'(1);
`else
  assign timeout = 1'b0;
  assign tw_illegal = STATUS_TW & !in_m;
`endif
  assign sret_bad = in_u | (in_s & STATUS_TSR);
  assign illegal = InstrValidM & ((mretM & !in_m) | (sretM & sret_bad) |
                                  (wfiM & ((P.S_SUPPORTED & in_u) | tw_illegal)));
  assign exc = (InstrValidM ? ExcM : '0) | {13'b0, illegal | timeout, 2'b0};
  trapcause u_trapcause (
    .int_en (int_en),
    .exc    (exc),
    .cause  (CauseM),
    .taken  (TrapM)
  );
  assign mideleg16 = {4'b0, MIDELEG_REGW};
  assign trap_deleg = CauseM[4] ? mideleg16[CauseM[3:0]] : MEDELEG_REGW[CauseM[3:0]];
  assign target = (trap_deleg & !in_m) ? S_MODE : M_MODE;
  assign mretValidM = InstrValidM & mretM & in_m & !TrapM;
  assign sretValidM = InstrValidM & sretM & !sret_bad & !TrapM;
  assign legal_wfi = InstrValidM & wfiM & !TrapM;
  assign NextPrivilegeModeM = TrapM ? target :
                              mretValidM ? STATUS_MPP :
                              sretValidM ? {1'b0, STATUS_SPP} : PrivilegeModeW;
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      PrivilegeModeW <= M_MODE;
    end else if (!StallW) begin
      PrivilegeModeW <= NextPrivilegeModeM;
      state <= wfi_wait ? ((wake | timeout) ? RUN : WFI) : ((legal_wfi & !wake) ? WFI : RUN);
    end
endmodule

// File: tb/tb_privtrap.sv
// tb_privtrap: directed checks of trap, return, delegation and WFI behaviour
module tb_privtrap;
  logic        clk = 1'b0, reset = 1'b1, StallW, InstrValidM, mretM, sretM, wfiM;
  logic [15:0] ExcM, MEDELEG_REGW;
  logic [11:0] MIP_REGW, MIE_REGW, MIDELEG_REGW;
  logic        STATUS_MIE, STATUS_SIE, STATUS_TSR, STATUS_TW, STATUS_SPP;
  logic [1:0]  STATUS_MPP;
  logic        TrapM, mretValidM, sretValidM, WFIStallM;
  logic [1:0]  NextPrivilegeModeM, PrivilegeModeW;
  logic [4:0]  CauseM;
  int errors = 0, checks = 0;

  privtrap dut (
    .clk(clk), .reset(reset), .StallW(StallW), .InstrValidM(InstrValidM),
    .mretM(mretM), .sretM(sretM), .wfiM(wfiM), .ExcM(ExcM),
    .MIP_REGW(MIP_REGW), .MIE_REGW(MIE_REGW), .MIDELEG_REGW(MIDELEG_REGW),
    .MEDELEG_REGW(MEDELEG_REGW), .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE),
    .STATUS_TSR(STATUS_TSR), .STATUS_TW(STATUS_TW), .STATUS_SPP(STATUS_SPP),
    .STATUS_MPP(STATUS_MPP), .TrapM(TrapM), .mretValidM(mretValidM),
    .sretValidM(sretValidM), .NextPrivilegeModeM(NextPrivilegeModeM),
    .PrivilegeModeW(PrivilegeModeW), .CauseM(CauseM), .WFIStallM(WFIStallM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    StallW = 0; InstrValidM = 0; mretM = 0; sretM = 0; wfiM = 0; ExcM = '0;
    MIP_REGW = '0; MIE_REGW = '0; MIDELEG_REGW = '0; MEDELEG_REGW = '0;
    STATUS_MIE = 0; STATUS_SIE = 0; STATUS_TSR = 0; STATUS_TW = 0; STATUS_SPP = 0;
    STATUS_MPP = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic enter_mode(input logic [1:0] m);
    do_reset();
    clear(); InstrValidM = 1; mretM = 1; STATUS_MPP = m;
    tick(); clear();
  endtask

  initial begin
    int n;
    clear();
    tick();
    #1;
    chk("reset_mode", PrivilegeModeW, 3);
    chk("reset_stall", WFIStallM, 0);
    chk("reset_cause", CauseM, 0);
    chk("reset_trap", TrapM, 0);
    // ecall from U delegated to S
    enter_mode(2'b00);
    chk("enter_u", PrivilegeModeW, 0);
    InstrValidM = 1; ExcM = 16'h0100; MEDELEG_REGW = 16'h0100; #1;
    chk("ecall_trap", TrapM, 1);
    chk("ecall_next", NextPrivilegeModeM, 1);
    chk("ecall_cause", CauseM, 5'h08);
    tick(); clear();
    chk("ecall_mode_w", PrivilegeModeW, 1);
    // sret in S with TSR is illegal
    enter_mode(2'b01);
    InstrValidM = 1; sretM = 1; STATUS_TSR = 1; #1;
    chk("tsr_trap", TrapM, 1);
    chk("tsr_cause", CauseM, 5'h02);
    chk("tsr_sretvalid", sretValidM, 0);
    chk("tsr_next", NextPrivilegeModeM, 3);
    STATUS_TSR = 0; STATUS_SPP = 0; #1;
    chk("sret_ok_valid", sretValidM, 1);
    chk("sret_ok_next", NextPrivilegeModeM, 0);
    clear();
    // mret in M to U, then mret in U is illegal
    do_reset();
    InstrValidM = 1; mretM = 1; STATUS_MPP = 2'b00; #1;
    chk("mret_valid", mretValidM, 1);
    chk("mret_trap", TrapM, 0);
    chk("mret_next", NextPrivilegeModeM, 0);
    tick();
    chk("mret_mode_w", PrivilegeModeW, 0);
    #1;
    chk("mret_u_trap", TrapM, 1);
    chk("mret_u_valid", mretValidM, 0);
    chk("mret_u_next", NextPrivilegeModeM, 3);
    MEDELEG_REGW = 16'h0004; #1;
    chk("mret_u_deleg_next", NextPrivilegeModeM, 1);
    clear();
    // delegated SEI: masked in S with SIE=0, taken in U, never in M
    enter_mode(2'b01);
    InstrValidM = 1; MIP_REGW = 12'h200; MIE_REGW = 12'h200; MIDELEG_REGW = 12'h200; #1;
    chk("sei_s_trap", TrapM, 0);
    enter_mode(2'b00);
    InstrValidM = 1; MIP_REGW = 12'h200; MIE_REGW = 12'h200; MIDELEG_REGW = 12'h200; #1;
    chk("sei_u_trap", TrapM, 1);
    chk("sei_u_cause", CauseM, 5'h19);
    chk("sei_u_next", NextPrivilegeModeM, 1);
    clear();
    do_reset();
    InstrValidM = 1; MIP_REGW = 12'h200; MIE_REGW = 12'h200; MIDELEG_REGW = 12'h200;
    STATUS_MIE = 1; STATUS_SIE = 1; #1;
    chk("sei_m_trap", TrapM, 0);
    // priorities in M
    MIDELEG_REGW = '0; MIP_REGW = 12'h0A0; MIE_REGW = 12'h0A0; ExcM = 16'h0008; #1;
    chk("int_prio_cause", CauseM, 5'h17);
    MIP_REGW = '0; ExcM = 16'h0005; #1;
    chk("exc_prio_2_0", CauseM, 5'h02);
    ExcM = 16'h1001; #1;
    chk("exc_prio_12_0", CauseM, 5'h0C);
    InstrValidM = 0; #1;
    chk("invalid_no_trap", TrapM, 0);
    clear();
    // wfi in M, woken by a pending but globally disabled interrupt
    InstrValidM = 1; wfiM = 1; #1;
    chk("wfi_no_trap", TrapM, 0);
    tick(); clear();
    chk("wfi_stall", WFIStallM, 1);
    tick();
    chk("wfi_stall_hold", WFIStallM, 1);
    MIP_REGW = 12'h080; MIE_REGW = 12'h080; StallW = 1; #1;
    chk("wfi_wake_trap", TrapM, 0);
    tick();
    chk("wfi_stallw_hold", WFIStallM, 1);
    StallW = 0; tick();
    chk("wfi_wake_stall", WFIStallM, 0);
    chk("wfi_wake_mode", PrivilegeModeW, 3);
    clear();
    // wfi woken by an enabled interrupt traps without a valid instruction
    InstrValidM = 1; wfiM = 1; tick(); clear();
    MIP_REGW = 12'h080; MIE_REGW = 12'h080; STATUS_MIE = 1; #1;
    chk("wfi_int_trap", TrapM, 1);
    chk("wfi_int_cause", CauseM, 5'h17);
    tick(); clear();
    chk("wfi_int_stall", WFIStallM, 0);
    // TW with mode below M
    enter_mode(2'b01);
    InstrValidM = 1; wfiM = 1; STATUS_TW = 1; #1;
`ifdef PRIVTRAP_WFI_TIMEOUT_EN
    chk("tw_no_trap", TrapM, 0);
    tick(); clear(); STATUS_TW = 1;
    n = -1;
    for (int i = 0; i < 300 && n < 0; i++) begin
      #1;
      if (TrapM) n = i;
      else tick();
    end
    chk("tw_timeout_cycle", n, 255);
`endif
    chk("tw_trap", TrapM, 1);
    chk("tw_cause", CauseM, 5'h02);
    chk("tw_next", NextPrivilegeModeM, 3);
    tick(); clear();
    chk("tw_stall", WFIStallM, 0);
    chk("tw_mode_w", PrivilegeModeW, 3);
    // reset in the middle of a wait
    enter_mode(2'b01);
    InstrValidM = 1; wfiM = 1; tick(); clear();
    chk("rst_wfi_stall", WFIStallM, 1);
    tick(); tick();
    reset = 1; tick(); #1;
    chk("rst_wfi_stall_clr", WFIStallM, 0);
    chk("rst_wfi_mode", PrivilegeModeW, 3);
    chk("rst_wfi_cause", CauseM, 0);
    reset = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
